// File: rtl/pong_referee_if.sv
// Referee-side signal bundle: GPIO-derived controls in, ball/score/state out.
interface pong_referee_if;
    logic       frame_tick;
    logic [9:0] y_pos_1;
    logic [9:0] y_pos_2;
    logic [1:0] ctrl;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [15:0] score;
    logic [2:0] state;
    logic       game_over;

    modport master (
        output frame_tick, y_pos_1, y_pos_2, ctrl,
        input  ball_x, ball_y, score, state, game_over
    );

    modport slave (
        input  frame_tick, y_pos_1, y_pos_2, ctrl,
        output ball_x, ball_y, score, state, game_over
    );
endinterface

// File: rtl/pong_referee.sv
// Pong game sequencer: ball motion, bounces, BCD scoring and
// the serve/play/point/over state machine, advanced once per frame.
module pong_referee #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE1_X    = 16,
    parameter int PADDLE2_X    = 616,
    parameter int SPEED        = 2,
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60
) (
    input logic           clk,
    input logic           reset,
    pong_referee_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0] CX = 10'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [9:0] CY = 10'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic signed [11:0] SP   = 12'(SPEED);
    localparam logic signed [11:0] BS   = 12'(BALL_SIZE);
    localparam logic signed [11:0] PH   = 12'(PADDLE_H);
    localparam logic signed [11:0] YMAX = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] XMAX = 12'(H_RES - BALL_SIZE);
    localparam logic signed [11:0] LHIT = 12'(PADDLE1_X + PADDLE_W);
    localparam logic signed [11:0] RHIT = 12'(PADDLE2_X - BALL_SIZE);
    localparam logic [7:0] WIN_BCD = 8'((WIN_SCORE / 10) * 16 + WIN_SCORE % 10);

    state_t        st;
    logic [CW-1:0] cnt;
    logic [9:0]    bx, by;
    logic          dx, dy;
    logic [15:0]   sc;
    logic          p1_scored;
    logic          over;

    logic signed [11:0] x, y, nx, ny, p1, p2;
    logic       ov1, ov2, hit, to_p1, run;
    logic [9:0] step_x, step_y;
    logic       step_dx, step_dy;
    logic [7:0] new_pair;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign run = bus.frame_tick && (bus.ctrl == 2'b01);

    always_comb begin
        x  = {2'b00, bx};
        y  = {2'b00, by};
        p1 = {2'b00, bus.y_pos_1};
        p2 = {2'b00, bus.y_pos_2};
        nx = dx ? x + SP : x - SP;
        ny = dy ? y + SP : y - SP;
        // overlap tests use the ball row before this frame's step
        ov1 = (y + BS > p1) && (y < p1 + PH);
        ov2 = (y + BS > p2) && (y < p2 + PH);
        step_x  = bx;
        step_dx = dx;
        hit     = 1'b0;
        to_p1   = 1'b0;
        if (!dx) begin
            if (nx <= LHIT && x >= LHIT && ov1) begin
                step_x  = LHIT[9:0];
                step_dx = 1'b1;
            end else if (nx <= 12'sd0) begin
                hit = 1'b1;
            end else begin
                step_x = nx[9:0];
            end
        end else begin
            if (nx >= RHIT && x <= RHIT && ov2) begin
                step_x  = RHIT[9:0];
                step_dx = 1'b0;
            end else if (nx >= XMAX) begin
                hit   = 1'b1;
                to_p1 = 1'b1;
            end else begin
                step_x = nx[9:0];
            end
        end
        step_y  = ny[9:0];
        step_dy = dy;
        if (ny <= 12'sd0) begin
            step_y  = 10'd0;
            step_dy = 1'b1;
        end else if (ny >= YMAX) begin
            step_y  = YMAX[9:0];
            step_dy = 1'b0;
        end
        new_pair = bcd_inc(p1_scored ? sc[15:8] : sc[7:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset || bus.ctrl[1]) begin
            st        <= IDLE;
            cnt       <= '0;
            bx        <= CX;
            by        <= CY;
            dx        <= 1'b1;
            dy        <= 1'b1;
            sc        <= 16'h0000;
            p1_scored <= 1'b0;
            over      <= 1'b0;
        end else begin
            unique case (st)
                IDLE: if (bus.ctrl == 2'b01) begin
                    st  <= SERVE;
                    cnt <= '0;
                end
                SERVE: if (run) begin
                    if (cnt == CW'(SERVE_FRAMES - 1)) st <= PLAY;
                    else cnt <= cnt + 1'b1;
                end
                PLAY: if (run) begin
                    if (hit) begin
                        p1_scored <= to_p1;
                        st        <= POINT;
                    end else begin
                        bx <= step_x;
                        by <= step_y;
                        dx <= step_dx;
                        dy <= step_dy;
                    end
                end
                POINT: begin
                    if (p1_scored) sc[15:8] <= new_pair;
                    else           sc[7:0]  <= new_pair;
                    bx <= CX;
                    by <= CY;
                    // serve toward the player who just conceded
                    dx <= p1_scored;
                    if (new_pair == WIN_BCD) begin
                        st   <= OVER;
                        over <= 1'b1;
                    end else begin
                        st  <= SERVE;
                        cnt <= '0;
                    end
                end
                OVER: ;
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.ball_x    = bx;
    assign bus.ball_y    = by;
    assign bus.score     = sc;
    assign bus.state     = st;
    assign bus.game_over = over;
endmodule
